// File: rtl/aes_inv_cipher_core_pkg.sv
// Shared AES-128 constants, types and inverse-round helper functions.
package aes_inv_cipher_core_pkg;

    localparam int NR     = 10;
    localparam int KIDX_W = 4;

    typedef logic [127:0] aes_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [7:0] get_byte(input aes_state_t s, input int j);
        return s[127-8*j -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by one of the InvMixColumns coefficients 09/0b/0d/0e.
    function automatic logic [7:0] gmul_inv(input logic [7:0] b, input logic [7:0] coef);
        logic [7:0] x2, x4, x8, res;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (coef)
            8'h09:   res = x8 ^ b;
            8'h0b:   res = x8 ^ x2 ^ b;
            8'h0d:   res = x8 ^ x4 ^ b;
            default: res = x8 ^ x4 ^ x2;
        endcase
        return res;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = get_byte(s, 4*((c - r + 4) % 4) + r);
            end
        end
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = get_byte(s, 4*c + r);
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = gmul_inv(a[r], 8'h0e) ^ gmul_inv(a[(r+1)%4], 8'h0b)
                                      ^ gmul_inv(a[(r+2)%4], 8'h0d) ^ gmul_inv(a[(r+3)%4], 8'h09);
            end
        end
        return o;
    endfunction

    function automatic aes_state_t add_round_key(input aes_state_t s, input aes_state_t k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_core_if.sv
// Block in/out handshakes plus the round-key lookup towards the key store.
interface aes_inv_cipher_core_if;
    import aes_inv_cipher_core_pkg::*;

    logic              in_valid;
    logic              in_ready;
    aes_state_t        data_in;
    logic [KIDX_W-1:0] key_idx;
    aes_state_t        rk;
    logic              out_valid;
    logic              out_ready;
    aes_state_t        data_out;
    logic              busy;

    modport slave (
        input  in_valid, data_in, rk, out_ready,
        output in_ready, key_idx, out_valid, data_out, busy
    );

    modport master (
        output in_valid, data_in, rk, out_ready,
        input  in_ready, key_idx, out_valid, data_out, busy
    );

endinterface

// File: rtl/aes_inv_cipher_core_inv_sbox.sv
// AES inverse S-box as a 256-entry combinational lookup table.
module aes_inv_cipher_core_inv_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign out_o = INV_SBOX[in_i];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys
// fetched by index from an external expanded-key store.
module aes_inv_cipher_core
    import aes_inv_cipher_core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    aes_inv_cipher_core_if.slave bus
);

    logic [1:0]        fsm_q, fsm_d;
    logic [KIDX_W-1:0] rnd_q, rnd_d;
    aes_state_t        state_q, state_d;
    aes_state_t        shifted, subbed, final_round, mid_round;

    assign shifted = inv_shift_rows(state_q);

    for (genvar j = 0; j < 16; j++) begin : g_sbox
        aes_inv_cipher_core_inv_sbox u_inv_sbox (
            .in_i  (shifted[127-8*j -: 8]),
            .out_o (subbed[127-8*j -: 8])
        );
    end

    // The last round skips InvMixColumns; both candidates share the same S-box bank.
    assign final_round = add_round_key(subbed, bus.rk);
    assign mid_round   = inv_mix_columns(final_round);

    assign bus.in_ready  = (fsm_q == ST_IDLE);
    assign bus.out_valid = (fsm_q == ST_DONE);
    assign bus.busy      = (fsm_q == ST_ROUND) || (fsm_q == ST_DONE);
    assign bus.data_out  = state_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        bus.key_idx = KIDX_W'(NR);
        case (fsm_q)
            ST_ROUND: bus.key_idx = rnd_q;
            ST_DONE:  bus.key_idx = '0;
            default:  bus.key_idx = KIDX_W'(NR);
        endcase
    end

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = add_round_key(bus.data_in, bus.rk);
                    rnd_d   = KIDX_W'(NR - 1);
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (rnd_q == '0) begin
                    state_d = final_round;
                    fsm_d   = ST_DONE;
                end else begin
                    state_d = mid_round;
                    rnd_d   = rnd_q - KIDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
                rnd_d = '0;
            end
        endcase
    end

    // NOTE: the datapath register is reset as well, so a reset mid-block leaves no partial plaintext behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            rnd_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Self-checking bench for aes_inv_cipher_core: FIPS-197 vectors, backpressure,
// back-to-back, mid-block reset and 1000 random blocks against a byte-level model.
module tb_aes_inv_cipher_core;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;

    logic [7:0]   fwd_sb [256];
    logic [7:0]   inv_sb [256];
    logic [127:0] rks    [16];
    logic [127:0] exp_q  [$];
    int           acc_cyc [$];

    aes_inv_cipher_core_if bus ();

    aes_inv_cipher_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Key-store model: combinational lookup by the requested index.
    assign bus.rk = rks[bus.key_idx];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- reference model: plain GF(2^8) arithmetic ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        for (int b = 1; b < 256; b++) begin
            if (gf_mul(a, 8'(b)) == 8'h01) return 8'(b);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sboxes();
        logic [7:0] b, s;
        for (int x = 0; x < 256; x++) begin
            b = gf_inv(8'(x));
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            fwd_sb[x] = s;
            inv_sb[s] = 8'(x);
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {fwd_sb[t[31:24]], fwd_sb[t[23:16]], fwd_sb[t[15:8]], fwd_sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 11; r < 16; r++) rks[r] = '0;
    endtask

    // Textbook inverse cipher on a 4x4 byte matrix s[row][col], byte 4*col+row.
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [127:0] pt;
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127-8*(4*c+r) -: 8] ^ rks[10][127-8*(4*c+r) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][(c + r) % 4] = s[r][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = inv_sb[t[r][c]] ^ rks[rnd][127-8*(4*c+r) -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) t[r][c] = s[r][c];
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(t[k][c], m[(k - r + 4) % 4]);
                        s[r][c] = acc;
                    end
                end
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                pt[127-8*(4*c+r) -: 8] = s[r][c];
        return pt;
    endfunction

    // ---------------- scoreboard: every accept must yield exactly one output ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model_decrypt(bus.data_in));
                acc_cyc.push_back(cyc);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                check("sb_output_expected", 128'(exp_q.size() > 0), 128'd1);
                if (exp_q.size() > 0) check("sb_data", bus.data_out, exp_q.pop_front());
            end
        end
    end

    task automatic wait_output(input string tag, input logic [127:0] exp, input bit rand_ready);
        int n    = 0;
        bit done = 1'b0;
        while (!done && n < 200) begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                check(tag, bus.data_out, exp);
                done = 1'b1;
            end
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        if (!done) check({tag, "_timeout"}, 128'(done), 128'd1);
    endtask

    initial begin
        logic [127:0] key, ct, pt;
        int n;

        build_sboxes();
        for (int i = 0; i < 16; i++) rks[i] = '0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        check("rst_in_ready",  128'(bus.in_ready),  128'd1);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_busy",      128'(bus.busy),      128'd0);
        check("rst_data_out",  bus.data_out,        128'd0);
        check("rst_key_idx",   128'(bus.key_idx),   128'd10);
        rst = 1'b0;
        tick();

        // FIPS-197 C.1: latency and key index sequence.
        load_key(KEY_C1);
        check("idle_key_idx", 128'(bus.key_idx), 128'd10);
        bus.data_in  = CT_C1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.data_in  = rand128();
        check("c1_busy",     128'(bus.busy),     128'd1);
        check("c1_in_ready", 128'(bus.in_ready), 128'd0);
        for (int k = 9; k >= 0; k--) begin
            check($sformatf("c1_key_idx_%0d", k), 128'(bus.key_idx), 128'(k));
            check("c1_no_early_valid", 128'(bus.out_valid), 128'd0);
            tick();
        end
        check("c1_valid_at_10", 128'(bus.out_valid), 128'd1);
        check("c1_plaintext",   bus.data_out,        PT_C1);

        // Backpressure in DONE with the next block (App. B) already offered.
        load_key(KEY_B);
        bus.data_in  = CT_B;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_out_valid", 128'(bus.out_valid), 128'd1);
            check("bp_data_hold", bus.data_out,        PT_C1);
            check("bp_in_ready",  128'(bus.in_ready),  128'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_idle_in_ready",  128'(bus.in_ready),  128'd1);
        check("bp_idle_out_valid", 128'(bus.out_valid), 128'd0);
        check("bp_idle_busy",      128'(bus.busy),      128'd0);
        tick();
        bus.in_valid = 1'b0;
        check("b_accepted_key_idx", 128'(bus.key_idx), 128'd9);
        wait_output("b_plaintext", PT_B, 1'b0);

        // Back-to-back: in_valid held high, out_ready held high.
        load_key(KEY_C1);
        bus.data_in   = CT_C1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check("b2b_c1_valid", 128'(bus.out_valid), 128'd1);
        check("b2b_c1_plain", bus.data_out,        PT_C1);
        load_key(KEY_B);
        bus.data_in = CT_B;
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("b2b_b_busy", 128'(bus.busy), 128'd1);
        wait_output("b2b_b_plain", PT_B, 1'b0);
        check("b2b_accept_gap", 128'(acc_cyc[$] - acc_cyc[$-1]), 128'd12);

        // Reset while rnd==5, then a fresh C.1 block.
        load_key(KEY_C1);
        bus.data_in  = CT_C1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        check("mid_key_idx_5", 128'(bus.key_idx), 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready",  128'(bus.in_ready),  128'd1);
        check("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("mid_rst_busy",      128'(bus.busy),      128'd0);
        check("mid_rst_key_idx",   128'(bus.key_idx),   128'd10);
        bus.data_in  = CT_C1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_output("post_rst_c1", PT_C1, 1'b1);

        // Random keys and ciphertexts with random input gaps and output stalls.
        for (int b = 0; b < 1000; b++) begin
            key = rand128();
            ct  = rand128();
            load_key(key);
            pt = model_decrypt(ct);
            repeat ($urandom_range(0, 2)) tick();
            bus.data_in  = ct;
            bus.in_valid = 1'b1;
            n = 0;
            while (!bus.in_ready && n < 20) begin
                tick();
                n++;
            end
            tick();
            bus.in_valid = 1'b0;
            bus.data_in  = rand128();
            wait_output("rand_block", pt, 1'b1);
        end

        tick();
        check("output_count",   128'(n_out),        128'd1005);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_core.md
Name: aes_inv_cipher_core

Overview:
- Iterative AES-128 decryption engine: the inverse-direction counterpart of the encryption round path (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns).
- Executes one inverse round per clock.
- Fetches round keys by index from the existing expanded-key store.
- Sits between the block-input buffer and the output buffer with valid/ready handshakes on both sides.

Parameters:
- NR, 10, number of cipher rounds. Only 10 (AES-128) is supported.
- KIDX_W, 4, width of the round-key index and of the internal round counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext block valid
- in_ready  out  1  engine can accept a block
- data_in  in  128  ciphertext, FIPS-197 byte order: byte j at bits [127-8j -: 8]
- key_idx  out  4  round-key index requested from the key store
- rk  in  128  round key for key_idx; combinational return in the same cycle
- out_valid  out  1  plaintext valid
- out_ready  in  1  downstream accepts plaintext
- data_out  out  128  plaintext, same byte order as data_in
- busy  out  1  high in ROUND or DONE

Behaviour:
- State encoding uses FIPS-197 layout: s[r][c] = byte 4c+r.
- InvShiftRows: s'[r][c] = s[r][(c-r) mod 4].
- FSM states: IDLE, ROUND, DONE. Registers: state (128), round counter rnd (4).
- Reset (synchronous): FSM=IDLE, rnd=0, state=0, out_valid=0, in_ready=1, busy=0, data_out=0.
- IDLE:
  - in_ready=1, key_idx=10.
  - On in_valid&in_ready: state <= data_in ^ rk, rnd <= 9, go to ROUND.
- ROUND, rnd in 9..1:
  - key_idx=rnd.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk).
  - rnd <= rnd-1.
- ROUND, rnd==0:
  - key_idx=0.
  - state <= InvSubBytes(InvShiftRows(state)) ^ rk, with no InvMixColumns.
  - Go to DONE.
- DONE:
  - out_valid=1, data_out=state, key_idx=0.
  - data_out holds stable while out_valid&!out_ready.
  - On out_ready: go to IDLE. out_valid drops on the next cycle.
- Latency:
  - Accept at edge T; out_valid is high from edge T+10.
  - Minimum block-to-block interval is 12 cycles.
  - in_ready is low in ROUND and DONE. No overlap: an in_valid held during DONE is accepted only after the return to IDLE.
- data_out is combinationally equal to state. It is meaningful only while out_valid=1.
- InvMixColumns uses the GF(2^8) polynomial 0x11B; coefficients {0e,0b,0d,09} are built from xtime chains with 8-bit wraparound reduction.
- key_idx is a pure function of FSM and rnd, glitch-free relative to register outputs. rk is sampled only on the updating edge.
- Reset mid-operation: the block in flight is discarded, the FSM returns to IDLE, and no partial output is ever presented.
- rnd never leaves 0..9. Any illegal FSM encoding recovers to IDLE.

Decomposition:
- aes_pkg holds:
  - NR
  - typedef aes_state_t (128 bits)
  - functions xtime, gmul_inv (x9/xb/xd/xe)
  - inv_shift_rows, inv_mix_columns, add_round_key
  - FSM state enum
- The encryption path can share xtime.
- One sub-module: aes_inv_sbox (8-bit combinational LUT, 256 entries), instantiated 16 times.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench key-store model, rk10=13111d7fe3944a17f307a78b4d2b30c5), data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept; key_idx sequence 10,9,...,1,0.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
- Backpressure: out_ready held low 5 cycles in DONE -> out_valid and data_out stable; in_ready=0; second in_valid not accepted until the cycle after the out handshake.
- Back-to-back: in_valid held high, out_ready=1, vectors C.1 then B -> both correct, accepts 12 cycles apart.
- Reset at ROUND rnd=5 -> next cycle IDLE, in_ready=1, out_valid=0; a fresh C.1 block then decrypts correctly.
- Random ciphertexts with random keys vs. software reference model, random ready/valid stalls -> 1000 blocks match, no lost or duplicated outputs.
